// File: rtl/can_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : can_rx_pkg
//  Description : Shared field codes, field lengths and the data-length helper
//                for the CAN receive frame sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package can_rx_pkg;

  // Field code presented on the sequencer's field output.
  typedef enum logic [3:0] {
    FIELD_IDLE    = 4'd0,
    FIELD_ID      = 4'd1,
    FIELD_CTRL    = 4'd2,
    FIELD_DATA    = 4'd3,
    FIELD_CRC     = 4'd4,
    FIELD_CRC_DEL = 4'd5,
    FIELD_ACK     = 4'd6,
    FIELD_ACK_DEL = 4'd7,
    FIELD_EOF     = 4'd8
  } field_e;

  localparam int unsigned ID_LEN        = 11;
  localparam int unsigned CTRL_LEN      = 7;
  localparam int unsigned CRC_LEN       = 15;
  localparam int unsigned EOF_LEN       = 7;
  localparam int unsigned MAX_DATA_BITS = 64;

  // Number of data-field bits: none for a remote frame, otherwise eight per
  // byte with DLC values above 8 saturating at eight bytes.
  function automatic logic [6:0] data_bits(input logic rtr, input logic [3:0] dlc);
    logic [6:0] len;
    if (rtr)
      len = 7'd0;
    else if (dlc[3])
      len = 7'(MAX_DATA_BITS);
    else
      len = {1'b0, dlc[2:0], 3'b000};
    return len;
  endfunction

endpackage
`default_nettype wire

// File: rtl/can_destuff_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : can_destuff_tracker
//  Description : Tracks the run of equal bus levels inside the stuff window
//                and flags the sampled bit that must be a stuff bit.
//  Ports       : clock, reset_n      - clock / async active-low reset
//                clear               - synchronous return to empty run
//                load                - start-of-frame: run = value 0, length 1
//                sample_point        - bit sample instant
//                window              - stuff window qualifier
//                rx_bit              - sampled bus level
//                stuff_bit           - current sampled bit is a stuff bit
//  Revision    : 1.0 - initial release
// ============================================================================
module can_destuff_tracker (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic load,
  input  logic sample_point,
  input  logic window,
  input  logic rx_bit,
  output logic stuff_bit
);

  logic [2:0] r_run_len;
  logic       r_run_val;

  // After five equal bits the next sampled bit is the inserted complement.
  assign stuff_bit = (r_run_len == 3'd5);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_run_len <= 3'd0;
      r_run_val <= 1'b0;
    end else if (clear) begin
      r_run_len <= 3'd0;
      r_run_val <= 1'b0;
    end else if (load) begin
      r_run_len <= 3'd1;
      r_run_val <= 1'b0;
    end else if (sample_point && window) begin
      // A stuff bit always opens a new run with its own level.
      if (stuff_bit || (rx_bit != r_run_val)) begin
        r_run_len <= 3'd1;
        r_run_val <= rx_bit;
      end else begin
        r_run_len <= r_run_len + 3'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rx_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : rx_frame_sequencer
//  Description : Base-format CAN receive frame sequencer. Walks the fields of
//                a frame on sample_point, removes stuff bits, captures the
//                header and CRC and reports frame status.
//  Ports       : clock, reset_n      - clock / async active-low reset
//                enable              - low forces IDLE with outputs cleared
//                sample_point, rx_bit- bit sample strobe and bus level
//                stuff_error         - stuff violation from the stuff monitor
//                stuffing_active     - stuff window qualifier (combinational)
//                field               - current field code
//                bit_valid, bit_out  - destuffed ID..CRC bit stream
//                stuff_skip          - a stuff bit was discarded
//                id_out, rtr_out, dlc_out, crc_rx - captured header / CRC
//                frame_start, frame_done, frame_abort, form_error - status
//  Revision    : 1.0 - initial release
// ============================================================================
module rx_frame_sequencer
  import can_rx_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        sample_point,
  input  logic        rx_bit,
  input  logic        stuff_error,
  output logic        stuffing_active,
  output logic [3:0]  field,
  output logic        bit_valid,
  output logic        bit_out,
  output logic        stuff_skip,
  output logic [10:0] id_out,
  output logic        rtr_out,
  output logic [3:0]  dlc_out,
  output logic [14:0] crc_rx,
  output logic        frame_start,
  output logic        frame_done,
  output logic        frame_abort,
  output logic        form_error
);

  localparam logic [3:0] S_IDLE    = FIELD_IDLE;
  localparam logic [3:0] S_ID      = FIELD_ID;
  localparam logic [3:0] S_CTRL    = FIELD_CTRL;
  localparam logic [3:0] S_DATA    = FIELD_DATA;
  localparam logic [3:0] S_CRC     = FIELD_CRC;
  localparam logic [3:0] S_CRC_DEL = FIELD_CRC_DEL;
  localparam logic [3:0] S_ACK     = FIELD_ACK;
  localparam logic [3:0] S_ACK_DEL = FIELD_ACK_DEL;
  localparam logic [3:0] S_EOF     = FIELD_EOF;

  localparam logic [6:0] C_ID_LAST   = 7'(ID_LEN - 1);
  localparam logic [6:0] C_CTRL_LAST = 7'(CTRL_LEN - 1);
  localparam logic [6:0] C_CRC_LAST  = 7'(CRC_LEN - 1);
  localparam logic [6:0] C_EOF_LAST  = 7'(EOF_LEN - 1);

  logic [3:0]  r_state;
  logic [6:0]  r_cnt;
  logic [6:0]  r_data_len;
  logic        r_bit_valid, r_bit_out, r_stuff_skip;
  logic [10:0] r_id;
  logic        r_rtr;
  logic [3:0]  r_dlc;
  logic [14:0] r_crc;
  logic        r_frame_start, r_frame_done, r_frame_abort, r_form_error;

  logic       w_window;
  logic       w_abort;
  logic       w_sof;
  logic       w_stuff_bit;
  logic [3:0] w_dlc_next;
  logic [6:0] w_len_next;

  // The IDLE term lets the stuff monitor see the SOF bit itself.
  assign w_window = (r_state == S_ID) || (r_state == S_CTRL) ||
                    (r_state == S_DATA) || (r_state == S_CRC) ||
                    ((r_state == S_IDLE) && !rx_bit);
  assign w_abort  = stuff_error && (r_state != S_IDLE);
  assign w_sof    = sample_point && (r_state == S_IDLE) && !rx_bit;

  // DLC and data length as they will be once the last CTRL bit is taken.
  assign w_dlc_next = {r_dlc[2:0], rx_bit};
  assign w_len_next = data_bits(r_rtr, w_dlc_next);

  can_destuff_tracker u_destuff (
    .clock        (clock),
    .reset_n      (reset_n),
    .clear        (!enable || w_abort),
    .load         (w_sof),
    .sample_point (sample_point),
    .window       (w_window),
    .rx_bit       (rx_bit),
    .stuff_bit    (w_stuff_bit)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= 7'd0;
      r_data_len    <= 7'd0;
      r_bit_valid   <= 1'b0;
      r_bit_out     <= 1'b0;
      r_stuff_skip  <= 1'b0;
      r_id          <= 11'd0;
      r_rtr         <= 1'b0;
      r_dlc         <= 4'd0;
      r_crc         <= 15'd0;
      r_frame_start <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame_abort <= 1'b0;
      r_form_error  <= 1'b0;
    end else begin
      r_bit_valid   <= 1'b0;
      r_bit_out     <= 1'b0;
      r_stuff_skip  <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame_abort <= 1'b0;
      r_form_error  <= 1'b0;

      if (!enable) begin
        r_state    <= S_IDLE;
        r_cnt      <= 7'd0;
        r_data_len <= 7'd0;
        r_id       <= 11'd0;
        r_rtr      <= 1'b0;
        r_dlc      <= 4'd0;
        r_crc      <= 15'd0;
      end else if (w_abort) begin
        // The bit sampled alongside the stuff error is dropped.
        r_frame_abort <= 1'b1;
        r_state       <= S_IDLE;
        r_cnt         <= 7'd0;
      end else if (sample_point) begin
        if (r_state == S_IDLE) begin
          if (!rx_bit) begin
            r_state       <= S_ID;
            r_cnt         <= 7'd0;
            r_frame_start <= 1'b1;
            r_id          <= 11'd0;
            r_rtr         <= 1'b0;
            r_dlc         <= 4'd0;
            r_crc         <= 15'd0;
          end
        end else if (w_window && w_stuff_bit) begin
          r_stuff_skip <= 1'b1;
        end else begin
          if (w_window) begin
            r_bit_valid <= 1'b1;
            r_bit_out   <= rx_bit;
          end
          case (r_state)
            S_ID: begin
              r_id <= {r_id[9:0], rx_bit};
              if (r_cnt == C_ID_LAST) begin
                r_state <= S_CTRL;
                r_cnt   <= 7'd0;
              end else begin
                r_cnt <= r_cnt + 7'd1;
              end
            end
            S_CTRL: begin
              if (r_cnt == 7'd0)
                r_rtr <= rx_bit;
              if (r_cnt >= 7'd3)
                r_dlc <= w_dlc_next;
              if ((r_cnt == 7'd1) && rx_bit) begin
                // Extended frames are not supported.
                r_form_error <= 1'b1;
                r_state      <= S_IDLE;
                r_cnt        <= 7'd0;
              end else if (r_cnt == C_CTRL_LAST) begin
                r_data_len <= w_len_next;
                r_state    <= (w_len_next == 7'd0) ? S_CRC : S_DATA;
                r_cnt      <= 7'd0;
              end else begin
                r_cnt <= r_cnt + 7'd1;
              end
            end
            S_DATA: begin
              if (r_cnt == (r_data_len - 7'd1)) begin
                r_state <= S_CRC;
                r_cnt   <= 7'd0;
              end else begin
                r_cnt <= r_cnt + 7'd1;
              end
            end
            S_CRC: begin
              r_crc <= {r_crc[13:0], rx_bit};
              if (r_cnt == C_CRC_LAST) begin
                r_state <= S_CRC_DEL;
                r_cnt   <= 7'd0;
              end else begin
                r_cnt <= r_cnt + 7'd1;
              end
            end
            S_CRC_DEL: begin
              if (!rx_bit) begin
                r_form_error <= 1'b1;
                r_state      <= S_IDLE;
              end else begin
                r_state <= S_ACK;
              end
            end
            S_ACK: begin
              // Either level is accepted in the ACK slot.
              r_state <= S_ACK_DEL;
            end
            S_ACK_DEL: begin
              if (!rx_bit) begin
                r_form_error <= 1'b1;
                r_state      <= S_IDLE;
              end else begin
                r_state <= S_EOF;
                r_cnt   <= 7'd0;
              end
            end
            S_EOF: begin
              if (!rx_bit) begin
                r_form_error <= 1'b1;
                r_state      <= S_IDLE;
                r_cnt        <= 7'd0;
              end else if (r_cnt == C_EOF_LAST) begin
                r_frame_done <= 1'b1;
                r_state      <= S_IDLE;
                r_cnt        <= 7'd0;
              end else begin
                r_cnt <= r_cnt + 7'd1;
              end
            end
            default: begin
              r_state <= S_IDLE;
              r_cnt   <= 7'd0;
            end
          endcase
        end
      end
    end
  end

  assign stuffing_active = w_window;
  assign field           = r_state;
  assign bit_valid       = r_bit_valid;
  assign bit_out         = r_bit_out;
  assign stuff_skip      = r_stuff_skip;
  assign id_out          = r_id;
  assign rtr_out         = r_rtr;
  assign dlc_out         = r_dlc;
  assign crc_rx          = r_crc;
  assign frame_start     = r_frame_start;
  assign frame_done      = r_frame_done;
  assign frame_abort     = r_frame_abort;
  assign form_error      = r_form_error;

endmodule
`default_nettype wire

// File: doc/rx_frame_sequencer.md
RX_FRAME_SEQUENCER -- requirements
Module: rx_frame_sequencer

Interface
REQ-001 The block SHALL have no parameters; all field lengths SHALL come from the shared package.
REQ-002 clock  in  1  system clock; all state SHALL change on its rising edge only.
REQ-003 reset_n  in  1  reset, asynchronous, active-low.
REQ-004 enable  in  1  controller enable; low SHALL behave as synchronous return to IDLE with outputs cleared.
REQ-005 sample_point  in  1  one-clock pulse marking the bit sample instant.
REQ-006 rx_bit  in  1  sampled bus level (0 dominant, 1 recessive).
REQ-007 stuff_error  in  1  registered stuff-violation pulse from the stuff monitor.
REQ-008 stuffing_active  out  1  combinational stuff-window qualifier for the stuff monitor.
REQ-009 field  out  4  current field code (field_e).
REQ-010 bit_valid, bit_out  out  1,1  one-clock pulse with the destuffed bit, for ID through CRC bits.
REQ-011 stuff_skip  out  1  one-clock pulse when a sampled bit is discarded as a stuff bit.
REQ-012 id_out[10:0], rtr_out, dlc_out[3:0], crc_rx[14:0]  out  captured header and CRC.
REQ-013 frame_start, frame_done, frame_abort, form_error  out  1 each  one-clock status pulses.

Function
REQ-014 States SHALL be IDLE, ID(11), CTRL(7: RTR, IDE, r0, DLC[3:0]), DATA, CRC(15), CRC_DEL(1), ACK(1), ACK_DEL(1), EOF(7); a bit counter SHALL track position within each state.
REQ-015 State and counter SHALL advance only on sample_point cycles; registered outputs SHALL update one clock after the sample_point cycle.
REQ-016 IDLE -> ID on sample_point with rx_bit=0 (SOF); frame_start SHALL pulse; the destuff run SHALL be set to value 0, length 1.
REQ-017 stuffing_active SHALL be 1 when state is ID, CTRL, DATA or CRC, or state is IDLE with rx_bit=0; 0 otherwise.
REQ-018 Destuff tracker: within the stuff window, on each sample_point, an equal bit SHALL increment the run length and a different bit SHALL set it to 1; after a run of 5, the next sampled bit SHALL be a stuff bit.
REQ-019 A stuff bit SHALL pulse stuff_skip, SHALL not advance the counter or state, and SHALL restart the run at length 1 with its own value.
REQ-020 Data length SHALL be 0 bits if RTR=1, else 8*min(DLC,8) bits; DLC 9-15 SHALL yield 64 bits; a zero length SHALL go CTRL -> CRC directly.
REQ-021 The IDE bit sampled as 1 SHALL raise form_error and return to IDLE; only base frames are supported.
REQ-022 A dominant bit in CRC_DEL, ACK_DEL or any EOF bit SHALL pulse form_error and return to IDLE; the ACK slot SHALL accept either level.
REQ-023 The final EOF bit sampled recessive SHALL pulse frame_done and return to IDLE.
REQ-024 A stuff_error in any non-IDLE state SHALL take priority over the same-cycle sample_point: it SHALL pulse frame_abort, return to IDLE and discard that bit.
REQ-025 id_out, rtr_out, dlc_out and crc_rx SHALL shift in MSB-first and SHALL hold until the next frame_start.

Reset
REQ-026 On reset_n low, state SHALL be IDLE, counters 0, run length 0, and every output 0 except stuffing_active, which SHALL follow REQ-017.
REQ-027 Reset asserted mid-frame SHALL abandon the frame without a frame_abort or frame_done pulse.

Structure
REQ-028 Package can_rx_pkg SHALL hold field_e and the constants ID_LEN=11, CTRL_LEN=7, CRC_LEN=15, EOF_LEN=7 and MAX_DATA_BITS=64.
REQ-029 The destuff run tracker SHALL be a sub-module named can_destuff_tracker; all other logic SHALL be inline.

Verification
REQ-030 ID=0x123, RTR=0, DLC=2, data 0xA5 0x3C, CRC=0x1234, correctly stuffed -> id_out=0x123, dlc_out=2, 16 data bit_valid pulses, crc_rx=0x1234, one frame_done.
REQ-031 ID=0x000 -> stuff_skip pulses after the 5th dominant bit (SOF counted), ID bit count unaffected, id_out=0x000.
REQ-032 RTR=1, DLC=4 -> zero DATA bit_valid pulses, field goes CTRL -> CRC, frame_done pulses.
REQ-033 DLC=15 -> exactly 64 DATA bit_valid pulses, dlc_out=15.
REQ-034 Dominant CRC_DEL -> form_error pulse, field=IDLE, no frame_done; next SOF is accepted.
REQ-035 stuff_error pulse at DATA bit 3 -> frame_abort pulse, IDLE; reset_n low at CRC bit 5 -> all outputs 0, no status pulse.
